// File: rtl/dcmctrl_spi_slave.sv
// SPI mode-0 slave front end for dcmctrl: oversamples the SPI pins in the clk domain, decodes a
// command byte plus an auto-incrementing byte burst, and drives the byte-wide register-file port.
module dcmctrl_spi_slave #(
  parameter int ADDR_BITS   = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_ss,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [7:0]           reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [7:0]           reg_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA_WR,
    ST_DATA_RD
  } state_t;

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  state_t                 state;
  state_t                 next_state;

  logic [SYNC_STAGES-1:0] ss_chain;
  logic [SYNC_STAGES-1:0] sclk_chain;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   ss_sync;
  logic                   sclk_sync;
  logic                   mosi_sync;

  logic [FILL_W-1:0]      fill_cnt;
  logic                   fill_done;
  logic                   ss_prev;
  logic                   sclk_prev;
  logic                   ss_fall;
  logic                   sclk_rise;

  logic [2:0]             bit_cnt;
  logic [7:0]             rx;
  logic [7:0]             rx_next;
  logic [7:0]             tx;
  logic                   byte_done;
  logic                   ld_pend;
  logic [ADDR_BITS-1:0]   ptr;

  assign ss_sync   = ss_chain[SYNC_STAGES-1];
  assign sclk_sync = sclk_chain[SYNC_STAGES-1];
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_chain   <= '1;
      sclk_chain <= '0;
      mosi_chain <= '0;
    end else begin
      ss_chain   <= {ss_chain[SYNC_STAGES-2:0], spi_ss};
      sclk_chain <= {sclk_chain[SYNC_STAGES-2:0], spi_clk};
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  // ss_prev only tracks ss once the chains hold real pin values, so an ss held low through
  // reset never looks like a falling edge; a fresh high-then-low is required.
  assign fill_done = (fill_cnt == FILL_W'(SYNC_STAGES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt  <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      if (!fill_done) fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_done) ss_prev <= ss_sync;
      sclk_prev <= sclk_sync;
    end
  end

  assign ss_fall   = ss_prev & ~ss_sync;
  assign sclk_rise = ~sclk_prev & sclk_sync;
  assign rx_next   = {rx[6:0], mosi_sync};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before any branch so no latch is inferred.
  always_comb begin
    next_state = state;
    if (ss_sync) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (ss_fall)   next_state = ST_CMD;
        ST_CMD:  if (byte_done) next_state = rx_next[7] ? ST_DATA_WR : ST_DATA_RD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_miso  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      ld_pend   <= 1'b0;
      ptr       <= '0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      ld_pend <= 1'b0;
      busy    <= ~ss_sync;
      if (ss_sync) begin
        spi_miso <= 1'b0;
        tx       <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            spi_miso <= 1'b0;
            tx       <= '0;
            if (ss_fall) begin
              bit_cnt <= '0;
              rx      <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              ptr <= ADDR_BITS'(rx_next[6:0]);
              // A read prefetches the first byte straight from the command address.
              if (!rx_next[7]) begin
                reg_re   <= 1'b1;
                reg_addr <= ADDR_BITS'(rx_next[6:0]);
              end
            end
          end
          ST_DATA_WR: begin
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              reg_we    <= 1'b1;
              reg_addr  <= ptr;
              reg_wdata <= rx_next;
              ptr       <= ptr + ADDR_BITS'(1);
            end
          end
          ST_DATA_RD: begin
            // reg_rdata is valid the cycle after reg_re, which is when ld_pend is high.
            ld_pend <= reg_re;
            if (ld_pend) begin
              tx       <= reg_rdata;
              spi_miso <= reg_rdata[7];
              ptr      <= ptr + ADDR_BITS'(1);
            end else if (sclk_rise) begin
              tx       <= {tx[6:0], 1'b0};
              spi_miso <= tx[6];
            end
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              reg_re   <= 1'b1;
              reg_addr <= ptr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcmctrl_spi_slave.sv
// Directed bench for dcmctrl_spi_slave: drives SPI mode-0 transfers, models the register file,
// and compares strobes and MISO bytes against hand-computed values.
module tb_dcmctrl_spi_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_ss = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [128];
  logic [6:0] we_addr_q [$];
  logic [7:0] we_data_q [$];
  logic [6:0] re_addr_q [$];
  int         both_cnt = 0;
  int         miso_hi_cnt = 0;

  logic [7:0] t2_data [4] = '{8'd100, 8'd0, 8'd0, 8'd80};
  logic [7:0] rb;
  logic [7:0] rd;
  int         n0, n1, r0, r1, m0, bad;

  always #5 clk = ~clk;

  dcmctrl_spi_slave #(.ADDR_BITS(7), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_ss    (spi_ss),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register-file model: read data appears exactly one clk after reg_re, junk otherwise.
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    reg_rdata <= reg_re ? mem[reg_addr] : 8'hEE;
  end

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
    if (spi_miso) miso_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the top n bits of d MSB first; MISO is sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = d[i];
      wait_clk(5);
      r[i] = spi_miso;
      spi_clk = 1'b1;
      wait_clk(5);
      spi_clk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    wait_clk(6);
    spi_ss = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #1;
    check("rst_miso",  32'(spi_miso),  32'h0);
    check("rst_addr",  32'(reg_addr),  32'h0);
    check("rst_wdata", 32'(reg_wdata), 32'h0);
    check("rst_we",    32'(reg_we),    32'h0);
    check("rst_re",    32'(reg_re),    32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    wait_clk(4);
    reset = 1'b0;
    wait_clk(6);
    check("idle_busy", 32'(busy), 32'h0);

    // Test 1: write burst from 0 covering the full address space.
    n0 = we_addr_q.size();
    r0 = re_addr_q.size();
    ss_begin();
    check("t1_busy", 32'(busy), 32'h1);
    spi_bits(8'h80, 8, rb);
    for (int i = 0; i < 128; i++) spi_bits(8'h00, 8, rb);
    ss_end();
    check("t1_we_count", 32'(we_addr_q.size() - n0), 32'd128);
    bad = 0;
    for (int i = 0; i < 128 && n0 + i < we_addr_q.size(); i++)
      if (we_addr_q[n0+i] != i[6:0] || we_data_q[n0+i] != 8'h00) bad++;
    check("t1_order", 32'(bad), 32'd0);
    check("t1_no_re", 32'(re_addr_q.size() - r0), 32'd0);

    // Test 2: write 100,0,0,80 starting at 64.
    n0 = we_addr_q.size();
    m0 = miso_hi_cnt;
    ss_begin();
    spi_bits(8'hC0, 8, rb);
    for (int i = 0; i < 4; i++) spi_bits(t2_data[i], 8, rb);
    ss_end();
    check("t2_we_count", 32'(we_addr_q.size() - n0), 32'd4);
    for (int i = 0; i < 4 && n0 + i < we_addr_q.size(); i++) begin
      check("t2_addr", 32'(we_addr_q[n0+i]), 32'(64 + i));
      check("t2_data", 32'(we_data_q[n0+i]), 32'(t2_data[i]));
    end
    check("t2_miso_low", 32'(miso_hi_cnt - m0), 32'd0);

    // Test 3: read back 64..67.
    r0 = re_addr_q.size();
    ss_begin();
    m0 = miso_hi_cnt;
    spi_bits(8'h40, 8, rb);
    check("t3_miso_cmd", 32'(miso_hi_cnt - m0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'h00, 8, rd);
      check("t3_miso_byte", 32'(rd), 32'(t2_data[i]));
    end
    ss_end();
    // The 8th rise of the last dummy byte also prefetches 68, hence five strobes.
    check("t3_re_count", 32'(re_addr_q.size() - r0), 32'd5);
    for (int i = 0; i < 5 && r0 + i < re_addr_q.size(); i++)
      check("t3_re_addr", 32'(re_addr_q[r0+i]), 32'(64 + i));

    // Test 4: write across 127 -> 0, then read across the same wrap.
    n0 = we_addr_q.size();
    ss_begin();
    spi_bits(8'hFF, 8, rb);
    spi_bits(8'hA5, 8, rb);
    spi_bits(8'h3C, 8, rb);
    ss_end();
    check("t4_we_count", 32'(we_addr_q.size() - n0), 32'd2);
    if (we_addr_q.size() >= n0 + 2) begin
      check("t4_we_addr0", 32'(we_addr_q[n0]),   32'd127);
      check("t4_we_addr1", 32'(we_addr_q[n0+1]), 32'd0);
    end
    r0 = re_addr_q.size();
    ss_begin();
    spi_bits(8'h7F, 8, rb);
    spi_bits(8'h00, 8, rd);
    check("t4_miso_a5", 32'(rd), 32'hA5);
    spi_bits(8'h00, 8, rd);
    check("t4_miso_3c", 32'(rd), 32'h3C);
    ss_end();
    check("t4_re_count", 32'(re_addr_q.size() - r0), 32'd3);
    if (re_addr_q.size() >= r0 + 2) begin
      check("t4_re_addr0", 32'(re_addr_q[r0]),   32'd127);
      check("t4_re_addr1", 32'(re_addr_q[r0+1]), 32'd0);
    end

    // Test 5: trailing partial byte is dropped; next transaction starts with a command.
    n0 = we_addr_q.size();
    ss_begin();
    spi_bits(8'hC5, 8, rb);
    spi_bits(8'h11, 8, rb);
    spi_bits(8'hFF, 5, rb);
    ss_end();
    check("t5_we_count", 32'(we_addr_q.size() - n0), 32'd1);
    if (we_addr_q.size() > n0) begin
      check("t5_addr", 32'(we_addr_q[n0]), 32'd69);
      check("t5_data", 32'(we_data_q[n0]), 32'h11);
    end
    ss_begin();
    spi_bits(8'hC6, 8, rb);
    spi_bits(8'h22, 8, rb);
    ss_end();
    check("t5_next_count", 32'(we_addr_q.size() - n0), 32'd2);
    if (we_addr_q.size() > n0 + 1) begin
      check("t5_next_addr", 32'(we_addr_q[n0+1]), 32'd70);
      check("t5_next_data", 32'(we_data_q[n0+1]), 32'h22);
    end

    // Test 6: asynchronous reset 3 bits into a data byte, ss held low across it.
    n0 = we_addr_q.size();
    ss_begin();
    spi_bits(8'h8A, 8, rb);
    spi_bits(8'h5A, 8, rb);
    spi_bits(8'hFF, 3, rb);
    check("t6_pre_we", 32'(we_addr_q.size() - n0), 32'd1);
    check("t6_pre_addr", 32'(reg_addr), 32'd10);
    check("t6_pre_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("t6_rst_miso",  32'(spi_miso),  32'h0);
    check("t6_rst_addr",  32'(reg_addr),  32'h0);
    check("t6_rst_wdata", 32'(reg_wdata), 32'h0);
    check("t6_rst_we",    32'(reg_we),    32'h0);
    check("t6_rst_re",    32'(reg_re),    32'h0);
    check("t6_rst_busy",  32'(busy),      32'h0);
    wait_clk(3);
    reset = 1'b0;
    n1 = we_addr_q.size();
    r1 = re_addr_q.size();
    spi_bits(8'hFF, 5, rb);
    spi_bits(8'h8C, 8, rb);
    spi_bits(8'h33, 8, rb);
    check("t6_post_we", 32'(we_addr_q.size() - n1), 32'd0);
    check("t6_post_re", 32'(re_addr_q.size() - r1), 32'd0);
    ss_end();
    ss_begin();
    spi_bits(8'h8B, 8, rb);
    spi_bits(8'h77, 8, rb);
    ss_end();
    check("t6_new_count", 32'(we_addr_q.size() - n1), 32'd1);
    if (we_addr_q.size() > n1) begin
      check("t6_new_addr", 32'(we_addr_q[n1]), 32'd11);
      check("t6_new_data", 32'(we_data_q[n1]), 32'h77);
    end

    check("we_re_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
